// File: rtl/core_mem_pkg.sv
// Shared types and sizing helpers for the core memory-port arbiter.
// Imported by the arbiter top and its grant sub-module.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int STARVE_LIMIT_DEF = 4;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(STARVE_LIMIT_DEF);

endpackage

// File: rtl/mem_arb_grant.sv
// Owner selection for the shared memory port: data first, with a
// bound on how many data grants may pass a waiting fetch.
module mem_arb_grant
    import core_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic pick_fetch
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;
    logic             starved;

    assign starved    = (cnt == CNT_W'(STARVE_LIMIT));
    assign pick_fetch = i_req && (!d_req || starved);

    // Only data grants made while fetch waits count toward starvation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!i_req) begin
            cnt <= '0;
        end else if (grant) begin
            cnt <= pick_fetch ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises fetch and data masters onto one Avalon-style memory port,
// holding each side's last read data until its next read completes.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_read_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_waitrequest,
    input  logic                d_read_en,
    input  logic                d_write_en,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_waitrequest,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_read,
    output logic                m_write,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid
);

    arb_state_t state;
    arb_state_t state_nx;
    arb_owner_t owner;

    logic d_req;
    logic any_req;
    logic grant;
    logic pick_fetch;
    logic accepted;
    logic rd_done;

    assign d_req    = d_read_en | d_write_en;
    assign any_req  = i_read_en | d_req;
    assign grant    = (state == IDLE) && any_req;
    assign accepted = (state == ISSUE) && !m_waitrequest;
    assign rd_done  = (state == WAIT_RD) && m_readdatavalid;

    mem_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_read_en),
        .d_req     (d_req),
        .grant     (grant),
        .pick_fetch(pick_fetch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   if (!m_waitrequest) state_nx = m_write ? DONE : WAIT_RD;
            WAIT_RD: if (m_readdatavalid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A simultaneous data read and write is issued as the write alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner        <= OWN_I;
            m_addr       <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            i_readdata   <= '0;
            d_readdata   <= '0;
        end else begin
            if (grant) begin
                if (pick_fetch) begin
                    owner        <= OWN_I;
                    m_addr       <= i_addr;
                    m_writedata  <= '0;
                    m_byteenable <= '1;
                    m_read       <= 1'b1;
                    m_write      <= 1'b0;
                end else begin
                    owner        <= OWN_D;
                    m_addr       <= d_addr;
                    m_writedata  <= d_writedata;
                    m_byteenable <= d_byteenable;
                    m_read       <= !d_write_en;
                    m_write      <= d_write_en;
                end
            end
            if (accepted) begin
                m_read  <= 1'b0;
                m_write <= 1'b0;
            end
            if (rd_done) begin
                if (owner == OWN_I) begin
                    i_readdata <= m_readdata;
                end else begin
                    d_readdata <= m_readdata;
                end
            end
        end
    end

    assign i_waitrequest = !((state == DONE) && (owner == OWN_I));
    assign d_waitrequest = !((state == DONE) && (owner == OWN_D));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: vector table of single
// transactions plus hand sequences for contention, stalls and reset.
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_read_en;
    logic [31:0] i_addr;
    logic [31:0] i_readdata;
    logic        i_waitrequest;
    logic        d_read_en;
    logic        d_write_en;
    logic [31:0] d_addr;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_readdata;
    logic        d_waitrequest;
    logic [31:0] m_addr;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_read_en      (i_read_en),
        .i_addr         (i_addr),
        .i_readdata     (i_readdata),
        .i_waitrequest  (i_waitrequest),
        .d_read_en      (d_read_en),
        .d_write_en     (d_write_en),
        .d_addr         (d_addr),
        .d_writedata    (d_writedata),
        .d_byteenable   (d_byteenable),
        .d_readdata     (d_readdata),
        .d_waitrequest  (d_waitrequest),
        .m_addr         (m_addr),
        .m_writedata    (m_writedata),
        .m_byteenable   (m_byteenable),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    // Slave model: optional stall, read data one cycle after acceptance.
    logic        slave_auto = 1'b1;
    logic        man_wait   = 1'b0;
    logic        man_rdv    = 1'b0;
    logic [31:0] man_rdata  = '0;
    logic [31:0] slave_rdata = '0;
    int          stall_cfg  = 0;
    logic        s_wait = 1'b0;
    logic        s_rdv  = 1'b0;
    logic        s_pend = 1'b0;
    logic        busy   = 1'b0;
    int          left   = 0;

    assign m_waitrequest   = slave_auto ? s_wait : man_wait;
    assign m_readdatavalid = slave_auto ? s_rdv : man_rdv;
    assign m_readdata      = slave_auto ? slave_rdata : man_rdata;

    always @(negedge clk) begin
        if (reset) begin
            s_pend = 1'b0;
            s_rdv  = 1'b0;
            s_wait = 1'b0;
            busy   = 1'b0;
        end else begin
            s_rdv  = s_pend;
            s_pend = 1'b0;
            if (m_read || m_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    left = stall_cfg;
                end
                if (left > 0) begin
                    s_wait = 1'b1;
                    left   = left - 1;
                end else begin
                    s_wait = 1'b0;
                    busy   = 1'b0;
                    if (m_read) s_pend = 1'b1;
                end
            end else begin
                s_wait = 1'b0;
                busy   = 1'b0;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        logic [31:0] sdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        int          exp_done;
        logic [31:0] exp_ird;
        logic [31:0] exp_drd;
    } vec_t;

    vec_t vecs[7];

    task automatic clear_reqs();
        i_read_en    = 1'b0;
        d_read_en    = 1'b0;
        d_write_en   = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int          cmd_cyc;
        int          done_cyc;
        logic        c_rd;
        logic        c_wr;
        logic [31:0] c_addr;
        logic [31:0] c_wd;
        logic [3:0]  c_be;
        logic        wrq;
        cmd_cyc  = -1;
        done_cyc = -1;
        c_rd = 0; c_wr = 0; c_addr = '0; c_wd = '0; c_be = '0;
        stall_cfg    = v.stall;
        slave_rdata  = v.sdata;
        i_read_en    = v.fetch;
        i_addr       = v.addr;
        d_read_en    = v.rd;
        d_write_en   = v.wr;
        d_addr       = v.addr;
        d_writedata  = v.wdata;
        d_byteenable = v.be;
        for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cmd_cyc < 0 && (m_read || m_write)) begin
                cmd_cyc = cyc;
                c_rd    = m_read;
                c_wr    = m_write;
                c_addr  = m_addr;
                c_wd    = m_writedata;
                c_be    = m_byteenable;
            end
            wrq = v.fetch ? i_waitrequest : d_waitrequest;
            if (!wrq) done_cyc = cyc;
        end
        clear_reqs();
        check($sformatf("v%0d_cmd_cyc", k), 32'(cmd_cyc), 32'd1);
        check($sformatf("v%0d_done_cyc", k), 32'(done_cyc),
              32'(v.exp_done));
        check($sformatf("v%0d_m_read", k), 32'(c_rd), 32'(v.exp_rd));
        check($sformatf("v%0d_m_write", k), 32'(c_wr), 32'(v.exp_wr));
        check($sformatf("v%0d_m_addr", k), c_addr, v.addr);
        check($sformatf("v%0d_m_be", k), 32'(c_be), 32'(v.exp_be));
        if (v.wr) check($sformatf("v%0d_m_wdata", k), c_wd, v.wdata);
        @(negedge clk);
        wrq = v.fetch ? i_waitrequest : d_waitrequest;
        check($sformatf("v%0d_pulse_end", k), 32'(wrq), 32'd1);
        check($sformatf("v%0d_i_rdata", k), i_readdata, v.exp_ird);
        check($sformatf("v%0d_d_rdata", k), d_readdata, v.exp_drd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    initial begin
        int          wcyc, rcyc, dlow, dlast, ilow, ilast;
        logic [31:0] waddr, raddr;
        logic [5:0]  pat;
        int          ngr;
        logic        prev;
        logic        stable;
        int          done;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0,
                    32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 3,
                    32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF, 0,
                    32'h0, 1'b0, 1'b1, 4'hF, 2,
                    32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 4'h3, 0,
                    32'hCAFEF00D, 1'b1, 1'b0, 4'h3, 3,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'h5, 0,
                    32'h0, 1'b0, 1'b1, 4'h5, 2,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h304, 32'h11112222, 4'hC, 0,
                    32'h99999999, 1'b0, 1'b1, 4'hC, 2,
                    32'hDEADBEEF, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0,
                    32'h01020304, 1'b1, 1'b0, 4'hF, 3,
                    32'h01020304, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h208, 32'h0, 4'hF, 2,
                    32'h0BADC0DE, 1'b1, 1'b0, 4'hF, 5,
                    32'h01020304, 32'h0BADC0DE};

        reset = 1'b1;
        clear_reqs();
        i_addr = '0; d_addr = '0; d_writedata = '0; d_byteenable = '0;
        repeat (2) @(negedge clk);
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_wdata", m_writedata, 32'h0);
        check("rst_m_be", 32'(m_byteenable), 32'h0);
        check("rst_i_rdata", i_readdata, 32'h0);
        check("rst_d_rdata", d_readdata, 32'h0);
        check("rst_i_wrq", 32'(i_waitrequest), 32'd1);
        check("rst_d_wrq", 32'(d_waitrequest), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);
        stall_cfg = 0;

        // Stray read data while idle must not be captured.
        slave_auto = 1'b0;
        man_rdv    = 1'b1;
        man_rdata  = 32'h55555555;
        @(negedge clk);
        man_rdv = 1'b0;
        @(negedge clk);
        check("stray_i_rdata", i_readdata, 32'h01020304);
        check("stray_d_rdata", d_readdata, 32'h0BADC0DE);
        slave_auto = 1'b1;

        // Contention: write first, fetch after one idle cycle.
        wcyc = -1; rcyc = -1; dlow = 0; dlast = -1; ilow = 0; ilast = -1;
        waddr = '0; raddr = '0;
        slave_rdata  = 32'h0F0F0F0F;
        i_read_en    = 1'b1;
        i_addr       = 32'h400;
        d_write_en   = 1'b1;
        d_addr       = 32'h200;
        d_writedata  = 32'h12345678;
        d_byteenable = 4'hF;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (m_write && wcyc < 0) begin wcyc = cyc; waddr = m_addr; end
            if (m_read && rcyc < 0) begin rcyc = cyc; raddr = m_addr; end
            if (!d_waitrequest) begin
                dlow++; dlast = cyc; d_write_en = 1'b0;
            end
            if (!i_waitrequest) begin
                ilow++; ilast = cyc; i_read_en = 1'b0;
            end
        end
        check("cont_wr_cyc", 32'(wcyc), 32'd1);
        check("cont_wr_addr", waddr, 32'h200);
        check("cont_rd_cyc", 32'(rcyc), 32'd4);
        check("cont_rd_addr", raddr, 32'h400);
        check("cont_d_low_n", 32'(dlow), 32'd1);
        check("cont_d_low_cyc", 32'(dlast), 32'd2);
        check("cont_i_low_n", 32'(ilow), 32'd1);
        check("cont_i_low_cyc", 32'(ilast), 32'd6);
        check("cont_i_rdata", i_readdata, 32'h0F0F0F0F);

        // Starvation: fetch waits behind exactly four data grants.
        pat  = '0;
        ngr  = 0;
        prev = 1'b0;
        i_read_en  = 1'b1;
        i_addr     = 32'h600;
        d_write_en = 1'b1;
        d_addr     = 32'h700;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if ((m_read || m_write) && !prev) begin
                if (ngr < 6) pat = {pat[4:0], m_read};
                ngr++;
            end
            prev = m_read || m_write;
            if (!i_waitrequest) i_read_en = 1'b0;
        end
        d_write_en = 1'b0;
        repeat (6) @(negedge clk);
        check("starve_grants", 32'(ngr >= 6), 32'd1);
        check("starve_order", 32'(pat), 32'b000010);

        // Slave stall on a data read: command held stable.
        stable = 1'b1;
        done   = -1;
        stall_cfg    = 5;
        slave_rdata  = 32'h13579BDF;
        d_read_en    = 1'b1;
        d_addr       = 32'h500;
        d_byteenable = 4'h6;
        for (int cyc = 1; cyc <= 20 && done < 0; cyc++) begin
            @(negedge clk);
            if (cyc <= 6) begin
                if (!(m_read && !m_write && m_addr == 32'h500
                      && m_byteenable == 4'h6)) stable = 1'b0;
            end
            if (!d_waitrequest) begin
                done = cyc; d_read_en = 1'b0;
            end
        end
        stall_cfg = 0;
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_done_cyc", 32'(done), 32'd8);
        check("stall_d_rdata", d_readdata, 32'h13579BDF);
        @(negedge clk);

        // Reset while the command is stalled in ISSUE.
        slave_auto = 1'b0;
        man_wait   = 1'b1;
        d_read_en  = 1'b1;
        d_addr     = 32'h800;
        @(negedge clk);
        check("rst_iss_pre", 32'(m_read), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_iss_m_read", 32'(m_read), 32'd0);
        check("rst_iss_m_addr", m_addr, 32'h0);
        d_read_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Reset in WAIT_RD, then a late read-data beat.
        man_wait  = 1'b0;
        d_read_en = 1'b1;
        d_addr    = 32'h900;
        @(negedge clk);
        check("rst_wrd_pre", 32'(m_read), 32'd1);
        @(negedge clk);
        d_read_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_wrd_d_wrq", 32'(d_waitrequest), 32'd1);
        @(negedge clk);
        reset     = 1'b0;
        man_rdv   = 1'b1;
        man_rdata = 32'h77777777;
        @(negedge clk);
        man_rdv = 1'b0;
        @(negedge clk);
        check("rst_late_d_rdata", d_readdata, 32'h0);
        check("rst_late_m_read", 32'(m_read), 32'd0);
        check("rst_late_d_wrq", 32'(d_waitrequest), 32'd1);
        slave_auto = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
